// File: rtl/dc1_xbit_ctl_if.sv
// dc1_xbit_ctl_if: the bus signals around the dc1_xbit protection-bit
// controller.
//
// The requester side carries the flush request and status, plus the two pbit
// write requesters wr0/wr1 with their grants.
//
// The array side carries the two RMW write ports write0/write1 and the
// bulk-insert path write_ins/write_data.
//
// Modports:
//   master - the requesters and the observer of the array-side outputs
//   slave  - the controller
interface dc1_xbit_ctl_if #(
`ifdef DCACHE_256K
    parameter int ADDR_WIDTH = 6
`else
    parameter int ADDR_WIDTH = 5
`endif
);
    localparam int AW = ADDR_WIDTH + 5;

    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;

    logic          wr0_req;
    logic [AW-1:0] wr0_addrE;
    logic [AW-1:0] wr0_addrO;
    logic          wr0_odd;
    logic [1:0]    wr0_pbit;
    logic          wr0_d128;
    logic          wr0_gnt;

    logic          wr1_req;
    logic [AW-1:0] wr1_addrE;
    logic [AW-1:0] wr1_addrO;
    logic          wr1_odd;
    logic [1:0]    wr1_pbit;
    logic          wr1_d128;
    logic          wr1_gnt;

    logic          write0_clkEn;
    logic [AW-1:0] write0_addrE;
    logic [AW-1:0] write0_addrO;
    logic          write0_odd;
    logic [1:0]    write0_pbit;
    logic          write0_d128;

    logic          write1_clkEn;
    logic [AW-1:0] write1_addrE;
    logic [AW-1:0] write1_addrO;
    logic          write1_odd;
    logic [1:0]    write1_pbit;
    logic          write1_d128;

    logic [1:0]    write_ins;
    logic [15:0]   write_data;

    modport master (
        output flush_req,
        output wr0_req, wr0_addrE, wr0_addrO, wr0_odd, wr0_pbit, wr0_d128,
        output wr1_req, wr1_addrE, wr1_addrO, wr1_odd, wr1_pbit, wr1_d128,
        input  flush_busy, flush_done, wr0_gnt, wr1_gnt,
        input  write0_clkEn, write0_addrE, write0_addrO, write0_odd, write0_pbit, write0_d128,
        input  write1_clkEn, write1_addrE, write1_addrO, write1_odd, write1_pbit, write1_d128,
        input  write_ins, write_data
    );

    modport slave (
        input  flush_req,
        input  wr0_req, wr0_addrE, wr0_addrO, wr0_odd, wr0_pbit, wr0_d128,
        input  wr1_req, wr1_addrE, wr1_addrO, wr1_odd, wr1_pbit, wr1_d128,
        output flush_busy, flush_done, wr0_gnt, wr1_gnt,
        output write0_clkEn, write0_addrE, write0_addrO, write0_odd, write0_pbit, write0_d128,
        output write1_clkEn, write1_addrE, write1_addrO, write1_odd, write1_pbit, write1_d128,
        output write_ins, write_data
    );
endinterface

// File: rtl/dc1_xbit_ctl.sv
// dc1_xbit_ctl: sequencer and arbiter in front of the L1 data-cache
// protection-bit array.
//
// Write arbitration:
//   - wr0 maps onto array port 0 and wr1 onto port 1.
//   - A request is held off when its key {odd, row} matches a write issued in
//     the previous cycle. The array's one-cycle RMW would otherwise drop the
//     earlier update.
//   - When both requests are eligible and their keys match, a round-robin bit
//     picks the winner.
//
// Flush: flush_req starts IDLE -> DRAIN -> SWEEP -> DONE. SWEEP clears every
// 16-bit half-row through write_ins/write_data.
//
// Ports:
//   clk - clock
//   rst - asynchronous, active-low reset
//   bus - dc1_xbit_ctl_if.slave: requesters, flush control and array ports
module dc1_xbit_ctl #(
`ifdef DCACHE_256K
    parameter int          ADDR_WIDTH = 6,
`else
    parameter int          ADDR_WIDTH = 5,
`endif
    parameter logic [15:0] FLUSH_DATA = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    dc1_xbit_ctl_if.slave       bus
);
    localparam int AW = ADDR_WIDTH + 5;
    localparam int KW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] addr0, addr1, sweep_addr;
    logic [KW-1:0] key0, key1;
    logic [KW-1:0] iss0_key_p1, iss1_key_p1;
    logic          iss0_vld_p1, iss1_vld_p1;
    logic          rr;
    logic          open, elig0, elig1, clash, gnt0, gnt1;

    assign addr0 = bus.wr0_odd ? bus.wr0_addrO : bus.wr0_addrE;
    assign addr1 = bus.wr1_odd ? bus.wr1_addrO : bus.wr1_addrE;
    assign key0  = {bus.wr0_odd, addr0[ADDR_WIDTH+3:4]};
    assign key1  = {bus.wr1_odd, addr1[ADDR_WIDTH+3:4]};

    // cnt[0] picks the 16-bit half, the upper bits pick the row
    assign sweep_addr = {cnt[0], cnt[ADDR_WIDTH:1], 4'b0000};

    // Grants are combinational. They are gated by rst so that every output is
    // 0 while reset is held.
    always_comb begin
        open  = rst && (state == IDLE);
        elig0 = open && bus.wr0_req
              && !(iss0_vld_p1 && key0 == iss0_key_p1)
              && !(iss1_vld_p1 && key0 == iss1_key_p1);
        elig1 = open && bus.wr1_req
              && !(iss0_vld_p1 && key1 == iss0_key_p1)
              && !(iss1_vld_p1 && key1 == iss1_key_p1);
        clash = elig0 && elig1 && (key0 == key1);
        gnt0  = elig0 && !(clash && rr);
        gnt1  = elig1 && !(clash && !rr);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:  if (bus.flush_req) state_nxt = DRAIN;
            DRAIN: begin
                cnt_nxt   = '0;
                state_nxt = SWEEP;
            end
            SWEEP: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {CW{1'b1}}) state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.wr0_gnt      = gnt0;
        bus.wr1_gnt      = gnt1;
        bus.flush_busy   = rst && (state == DRAIN || state == SWEEP);
        bus.flush_done   = rst && (state == DONE);
        bus.write0_clkEn = gnt0;
        bus.write0_addrE = '0;
        bus.write0_addrO = '0;
        bus.write0_odd   = 1'b0;
        bus.write0_pbit  = 2'b00;
        bus.write0_d128  = 1'b0;
        bus.write1_clkEn = gnt1;
        bus.write1_addrE = '0;
        bus.write1_addrO = '0;
        bus.write1_odd   = 1'b0;
        bus.write1_pbit  = 2'b00;
        bus.write1_d128  = 1'b0;
        bus.write_ins    = 2'b00;
        bus.write_data   = 16'h0000;
        if (gnt0) begin
            bus.write0_addrE = bus.wr0_addrE;
            bus.write0_addrO = bus.wr0_addrO;
            bus.write0_odd   = bus.wr0_odd;
            bus.write0_pbit  = bus.wr0_pbit;
            bus.write0_d128  = bus.wr0_d128;
        end
        if (gnt1) begin
            bus.write1_addrE = bus.wr1_addrE;
            bus.write1_addrO = bus.wr1_addrO;
            bus.write1_odd   = bus.wr1_odd;
            bus.write1_pbit  = bus.wr1_pbit;
            bus.write1_d128  = bus.wr1_d128;
        end
        // The bulk-insert path takes its row/half from write0's address
        // buses, so both banks are cleared with a single address.
        if (rst && state == SWEEP) begin
            bus.write_ins    = 2'b11;
            bus.write_data   = FLUSH_DATA;
            bus.write0_addrE = sweep_addr;
            bus.write0_addrO = sweep_addr;
        end
    end

    // Stage p0 -> p1: record this cycle's issued writes for the next cycle's
    // hazard check. DRAIN and DONE issue nothing, so the valid bits are
    // already clear when the sweep returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            iss0_vld_p1 <= 1'b0;
            iss1_vld_p1 <= 1'b0;
            rr          <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            iss0_vld_p1 <= gnt0;
            iss1_vld_p1 <= gnt1;
            if (clash) rr <= ~rr;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt0) iss0_key_p1 <= key0;
        if (gnt1) iss1_key_p1 <= key1;
    end
endmodule
